// File: rtl/sumador_if.sv
// Operand/result bundle for the registered ripple-carry adder.
interface sumador_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIn;
  logic             in_valid;
  logic [WIDTH-1:0] Sum;
  logic             COut;
  logic             ovf;
  logic             out_valid;

  modport master (
    output A, B, CIn, in_valid,
    input  Sum, COut, ovf, out_valid
  );

  modport slave (
    input  A, B, CIn, in_valid,
    output Sum, COut, ovf, out_valid
  );
endinterface

// File: rtl/sumador.sv
// Registered ripple-carry adder: {COut,Sum} = A + B + CIn, one-cycle latency,
// with two's-complement overflow and a single-cycle result strobe.
module sumador #(
  parameter int unsigned WIDTH = 1
) (
  input logic     clk,
  input logic     rst,
  sumador_if.slave bus
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_raw;
  logic             ovf_raw;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             valid_d, valid_q;

  always_comb begin
    carry    = '0;
    sum_raw  = '0;
    carry[0] = bus.CIn;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_raw[i]   = bus.A[i] ^ bus.B[i] ^ carry[i];
      carry[i+1]   = (bus.A[i] & bus.B[i]) | (bus.A[i] & carry[i]) | (bus.B[i] & carry[i]);
    end
    ovf_raw = carry[WIDTH] ^ carry[WIDTH-1];
  end

  // Result registers hold when idle so unqualified inputs never reach the outputs.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      sum_d  = sum_raw;
      cout_d = carry[WIDTH];
      ovf_d  = ovf_raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Sum       = sum_q;
  assign bus.COut      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_sumador.sv
// Bench for sumador at WIDTH=1 and WIDTH=8 against an arithmetic reference model.
module tb_sumador;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sumador_if #(.WIDTH(1)) b1 ();
  sumador_if #(.WIDTH(8)) b8 ();

  sumador #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  sumador #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  // Expected registered state of each DUT.
  logic       e1_sum, e1_cout, e1_ovf, e1_valid;
  logic [7:0] e8_sum;
  logic       e8_cout, e8_ovf, e8_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".w1.Sum"},       64'(b1.Sum),       64'(e1_sum));
    check({tag, ".w1.COut"},      64'(b1.COut),      64'(e1_cout));
    check({tag, ".w1.ovf"},       64'(b1.ovf),       64'(e1_ovf));
    check({tag, ".w1.out_valid"}, 64'(b1.out_valid), 64'(e1_valid));
    check({tag, ".w8.Sum"},       64'(b8.Sum),       64'(e8_sum));
    check({tag, ".w8.COut"},      64'(b8.COut),      64'(e8_cout));
    check({tag, ".w8.ovf"},       64'(b8.ovf),       64'(e8_ovf));
    check({tag, ".w8.out_valid"}, 64'(b8.out_valid), 64'(e8_valid));
  endtask

  task automatic model_reset();
    e1_sum = 1'b0; e1_cout = 1'b0; e1_ovf = 1'b0; e1_valid = 1'b0;
    e8_sum = '0;   e8_cout = 1'b0; e8_ovf = 1'b0; e8_valid = 1'b0;
  endtask

  // Reference: plain integer addition; overflow = operands share a sign that the result lacks.
  task automatic model_step(input logic v1, input logic a1, input logic bb1, input logic c1,
                            input logic v8, input logic [7:0] a8, input logic [7:0] bb8, input logic c8);
    int unsigned t;
    e1_valid = v1;
    if (v1) begin
      t       = int'(a1) + int'(bb1) + int'(c1);
      e1_sum  = t[0];
      e1_cout = t[1];
      e1_ovf  = (a1 == bb1) && (t[0] != a1);
    end
    e8_valid = v8;
    if (v8) begin
      t       = int'(a8) + int'(bb8) + int'(c8);
      e8_sum  = t[7:0];
      e8_cout = t[8];
      e8_ovf  = (a8[7] == bb8[7]) && (t[7] != a8[7]);
    end
  endtask

  task automatic cycle(input string tag,
                       input logic v1, input logic a1, input logic bb1, input logic c1,
                       input logic v8, input logic [7:0] a8, input logic [7:0] bb8, input logic c8);
    @(negedge clk);
    b1.in_valid = v1; b1.A = a1; b1.B = bb1; b1.CIn = c1;
    b8.in_valid = v8; b8.A = a8; b8.B = bb8; b8.CIn = c8;
    @(posedge clk);
    #1;
    model_step(v1, a1, bb1, c1, v8, a8, bb8, c8);
    check_all(tag);
  endtask

  initial begin
    logic [1:0] tbl [8];
    logic [2:0] idx;
    tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    b1.in_valid = 1'b0; b1.A = '0; b1.B = '0; b1.CIn = 1'b0;
    b8.in_valid = 1'b0; b8.A = '0; b8.B = '0; b8.CIn = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive WIDTH=1, {B,A,CIn} = 0..7 back-to-back.
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      cycle("exh", 1'b1, idx[1], idx[2], idx[0], 1'b0, 8'h00, 8'h00, 1'b0);
      check("exh.table", 64'({b1.COut, b1.Sum}), 64'(tbl[i]));
    end

    // Hold: accept 1+1, then idle with changed inputs.
    cycle("hold.load", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("hold.load.valid", 64'(b1.out_valid), 64'd1);
    cycle("hold.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("hold.idle.sum_cout", 64'({b1.COut, b1.Sum}), 64'b10);
    check("hold.idle.valid", 64'(b1.out_valid), 64'd0);

    // Idle with unknown operands must not disturb held results.
    cycle("xhold", 1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 8'hxx, 8'hxx, 1'bx);

    // Overflow and width corner cases.
    cycle("ovf1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0);
    check("ovf1.w1", 64'({b1.ovf, b1.COut, b1.Sum}), 64'b101);
    check("w8.ff01", 64'({b8.ovf, b8.COut, b8.Sum}), 64'h100);
    cycle("w8.7f", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h7F, 8'h00, 1'b1);
    check("w8.7f00c", 64'({b8.ovf, b8.COut, b8.Sum}), 64'h280);
    cycle("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    check("wrap.w8", 64'({b8.COut, b8.Sum}), 64'h1FF);

    // Reset mid-cycle with an operation pending.
    cycle("pre_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0);
    check("pre_rst.w1", 64'({b1.COut, b1.Sum}), 64'b11);
    b1.in_valid = 1'b1; b1.A = 1'b1; b1.B = 1'b0; b1.CIn = 1'b0;
    b8.in_valid = 1'b1; b8.A = 8'h55; b8.B = 8'h11; b8.CIn = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst.async");
    @(posedge clk);
    #1;
    check_all("rst.held");
    @(negedge clk);
    rst = 1'b0;
    b1.in_valid = 1'b0;
    b8.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst.no_pulse");
    cycle("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      cycle("rand", ($urandom_range(3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sumador.md
SUMADOR -- requirements
Module: sumador

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits; legal values 1 to 64.
REQ-002 Ports are as follows; the block has one clock, and reset is asynchronous and active-high.
REQ-003 Port: clk, input, 1 bit, sole clock; all state updates on the rising edge.
REQ-004 Port: rst, input, 1 bit, asynchronous active-high reset.
REQ-005 Port: A, input, WIDTH bits, addend A, unsigned.
REQ-006 Port: B, input, WIDTH bits, addend B, unsigned.
REQ-007 Port: CIn, input, 1 bit, carry-in.
REQ-008 Port: in_valid, input, 1 bit, qualifies A/B/CIn this cycle.
REQ-009 Port: Sum, output, WIDTH bits, registered sum bits.
REQ-010 Port: COut, output, 1 bit, registered carry-out.
REQ-011 Port: ovf, output, 1 bit, registered two's-complement overflow flag.
REQ-012 Port: out_valid, output, 1 bit, high for exactly one cycle per accepted operation.

Function
REQ-013 Arithmetic SHALL be {COut, Sum} = A + B + CIn, computed at WIDTH+1 bits with no truncation of the carry.
REQ-014 The adder SHALL be a ripple of per-bit full-adder cells:
- s_i = a_i ^ b_i ^ c_i
- c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i
- c_0 = CIn
REQ-015 ovf SHALL equal c_WIDTH XOR c_(WIDTH-1); for WIDTH=1 this is COut XOR CIn.
REQ-016 On a rising clk with in_valid=1, Sum, COut and ovf SHALL load the new result, and out_valid SHALL be set to 1.
REQ-017 On a rising clk with in_valid=0, Sum, COut and ovf SHALL hold their previous values, and out_valid SHALL be set to 0.
REQ-018 Latency SHALL be exactly 1 clock from the accepting edge to the result; throughput is one operation per cycle, back-to-back.
REQ-019 Outputs SHALL NOT change between clock edges except on reset assertion.
REQ-020 The block has no backpressure; every in_valid=1 cycle is accepted.
REQ-021 Wrap-around: for all-ones A and B with CIn=1, Sum SHALL be all ones and COut=1.
REQ-022 X/Z on A, B or CIn while in_valid=0 SHALL NOT affect the outputs.

Reset
REQ-023 Asserting rst SHALL immediately, without waiting for clk, force Sum=0, COut=0, ovf=0 and out_valid=0.
REQ-024 While rst=1, all inputs SHALL be ignored.
REQ-025 After rst deasserts, the first rising clk with in_valid=1 SHALL be accepted normally.
REQ-026 An operation in flight when rst asserts SHALL be discarded; out_valid SHALL NOT pulse for it.

Verification
REQ-027 Exhaustive test, WIDTH=1, in_valid=1, inputs {B,A,CIn} stepped 0..7 one per clock. Required {COut,Sum} one cycle later, in order: 00, 01, 01, 10, 01, 10, 10, 11.
REQ-028 Hold test, WIDTH=1. Drive A=1, B=1, CIn=0 with in_valid=1, then in_valid=0 with A=0, B=0. Required: Sum=0 and COut=1 hold, with out_valid pulsing for one cycle only.
REQ-029 Reset test. Assert rst mid-cycle while Sum=1 and COut=1. Required: all outputs are 0 before the next clk edge, and no out_valid pulse follows for the discarded operation.
REQ-030 Overflow test, WIDTH=1. Drive A=0, B=0, CIn=1. Required: Sum=1, COut=0, ovf=1.
REQ-031 Width test, WIDTH=8. Drive A=0xFF, B=0x01, CIn=0. Required: Sum=0x00, COut=1, ovf=0.
REQ-032 Width test, WIDTH=8. Drive A=0x7F, B=0x00, CIn=1. Required: Sum=0x80, COut=0, ovf=1.
